// File: rtl/sfx_pkg.sv
// Shared definitions for sfx_player: note codes, note frequencies in centi-Hz,
// the elaboration-time half-period helper and the default effect ROMs.
package sfx_pkg;

   typedef logic [4:0] note_t;

   localparam note_t REST = 5'd0;
   localparam note_t L1 = 5'd1,  L2 = 5'd2,  L3 = 5'd3,  L4 = 5'd4,  L5 = 5'd5,  L6 = 5'd6,  L7 = 5'd7;
   localparam note_t M1 = 5'd8,  M2 = 5'd9,  M3 = 5'd10, M4 = 5'd11, M5 = 5'd12, M6 = 5'd13, M7 = 5'd14;
   localparam note_t H1 = 5'd15, H2 = 5'd16, H3 = 5'd17, H4 = 5'd18, H5 = 5'd19, H6 = 5'd20, H7 = 5'd21;
   localparam note_t END = 5'd31;

   localparam int N_NOTES = 22;
   localparam int unsigned FREQ_CHZ [N_NOTES] = '{
      0,
      26160, 29370, 32960, 34920, 39200, 44000, 49390,
      52330, 58730, 65930, 69850, 78400, 88000, 98780,
      104650, 117470, 131850, 139700, 156800, 176000, 197550
   };

   localparam int ROM_N   = 4;
   localparam int ROM_LEN = 8;
   localparam note_t SFX_ROM [ROM_N][ROM_LEN] = '{
      '{H3, H5, END, END, END, END, END, END},
      '{M2, END, END, END, END, END, END, END},
      '{M5, M3, M1, END, END, END, END, END},
      '{M5, M4, M3, M2, L1, REST, L1, END}
   };

   // Codes 22..31 carry no pitch and play as silence.
   function automatic logic is_rest(input note_t n);
      return (n == REST) || (n > H7);
   endfunction

   // Rounded CLK_HZ / (2 * f), with f held in centi-Hz.
   function automatic int unsigned half_period(input longint unsigned clk_hz, input note_t n);
      longint unsigned f;
      if (is_rest(n)) return 0;
      f = 64'(FREQ_CHZ[n]);
      return 32'((clk_hz * 64'd100 + f) / (64'd2 * f));
   endfunction

   function automatic note_t rom_note(input int sfx, input int slot);
      if (sfx >= ROM_N || slot >= ROM_LEN) return END;
      return SFX_ROM[sfx[1:0]][slot[2:0]];
   endfunction

endpackage

// File: rtl/tone_div.sv
// Square-wave divider: counts 0..half_period-1 and toggles the wave as the count reaches
// half_period-1; clear zeroes count and wave, hold freezes both.
module tone_div #(
   parameter int DIV_W = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             hold,
   input  logic [DIV_W-1:0] half_period,
   output logic             wave
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             wave_q, wave_d;
   logic [DIV_W:0]   cnt_inc;

   assign cnt_inc = {1'b0, cnt_q} + 1'b1;

   always_comb begin
      cnt_d  = cnt_q;
      wave_d = wave_q;
      if (clear) begin
         cnt_d  = '0;
         wave_d = 1'b0;
      end else if (!hold) begin
         cnt_d = (cnt_inc >= {1'b0, half_period}) ? '0 : cnt_inc[DIV_W-1:0];
         if (({1'b0, cnt_d} + 1'b1) == {1'b0, half_period}) begin
            wave_d = ~wave_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         wave_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wave_q <= wave_d;
      end
   end

   assign wave = wave_q;

endmodule

// File: rtl/sfx_player.sv
// Priority sound-effect sequencer: trig -> busy/sfx_id next cycle, lower index pre-empts,
// other triggers during play are dropped. Build option SFX_LOOP_EN adds the loop input.
module sfx_player
   import sfx_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int UNIT_CYCLES = 5_000_000,
   parameter int N_SFX       = 4,
   parameter int SEQ_LEN     = 8,
   parameter int DIV_W       = 20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_SFX-1:0]         trig,
`ifdef SFX_LOOP_EN
   input  logic                     loop,
`endif
   output logic                     speaker,
   output logic                     busy,
   output logic [$clog2(N_SFX)-1:0] sfx_id,
   output logic                     done
);

   localparam int ID_W = $clog2(N_SFX);
   localparam int SL_W = $clog2(SEQ_LEN + 1);
   localparam int UC_W = $clog2(UNIT_CYCLES + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_PLAY = 1'b1;

   // Extra END column at SEQ_LEN lets the look-ahead index one past the last slot.
   note_t            rom_tab [N_SFX][SEQ_LEN+1];
   logic [DIV_W-1:0] hp_tab  [32];

   for (genvar s = 0; s < N_SFX; s++) begin : g_rom
      for (genvar k = 0; k <= SEQ_LEN; k++) begin : g_slot
         assign rom_tab[s][k] = (k == SEQ_LEN) ? END : rom_note(s, k);
      end
   end

   for (genvar g = 0; g < 32; g++) begin : g_hp
      localparam int unsigned HP = half_period(64'(CLK_HZ), note_t'(g));
      assign hp_tab[g] = DIV_W'(HP);
   end

   logic [0:0]      state_q, state_d;
   logic [ID_W-1:0] sfx_q, sfx_d, trig_idx;
   logic [SL_W-1:0] slot_q, slot_d, nxt_slot;
   logic [UC_W-1:0] ucnt_q, ucnt_d;
   logic            done_q, done_d;
   logic            loop_en, trig_any, boundary, last, start, div_clear;
   note_t           cur_note;

`ifdef SFX_LOOP_EN
   assign loop_en = loop;
`else
   assign loop_en = 1'b0;
`endif

   assign trig_any = |trig;
   assign cur_note = rom_tab[sfx_q][slot_q];
   assign nxt_slot = slot_q + 1'b1;
   assign boundary = (state_q == S_PLAY) && (ucnt_q == UC_W'(UNIT_CYCLES - 1));
   assign last     = (nxt_slot == SL_W'(SEQ_LEN)) || (rom_tab[sfx_q][nxt_slot] == END);

   always_comb begin
      trig_idx = '0;
      for (int i = N_SFX - 1; i >= 0; i--) begin
         if (trig[i]) trig_idx = ID_W'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      sfx_d   = sfx_q;
      slot_d  = slot_q;
      ucnt_d  = ucnt_q;
      done_d  = 1'b0;
      start   = 1'b0;
      if (state_q == S_IDLE) begin
         start = trig_any;
      end else if (boundary && last && !loop_en) begin
         // Natural finish; a trigger landing on this cycle is still taken.
         done_d  = 1'b1;
         state_d = S_IDLE;
         slot_d  = '0;
         ucnt_d  = '0;
         start   = trig_any;
      end else if (trig_any && (trig_idx < sfx_q)) begin
         start = 1'b1;
      end else if (boundary) begin
         slot_d = last ? '0 : nxt_slot;
         ucnt_d = '0;
      end else begin
         ucnt_d = ucnt_q + 1'b1;
      end
      if (start) begin
         state_d = S_PLAY;
         sfx_d   = trig_idx;
         slot_d  = '0;
         ucnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sfx_q   <= '0;
         slot_q  <= '0;
         ucnt_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sfx_q   <= sfx_d;
         slot_q  <= slot_d;
         ucnt_q  <= ucnt_d;
         done_q  <= done_d;
      end
   end

   assign div_clear = (state_q == S_IDLE) || boundary || start;

   tone_div #(
      .DIV_W(DIV_W)
   ) u_tone_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (div_clear),
      .hold        (is_rest(cur_note)),
      .half_period (hp_tab[cur_note]),
      .wave        (speaker)
   );

   assign busy   = (state_q == S_PLAY);
   assign sfx_id = sfx_q;
   assign done   = done_q;

endmodule
